// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM state encoding and default widths for alu_seq
// Contents:
//   ALU_SEQ_WIDTH / ALU_SEQ_OPRN_WIDTH  default data and opcode widths
//   ALU_SEQ_OP_*                        opcode constants (8-bit, cast to OPRN_WIDTH at use)
//   alu_seq_state_e                     IDLE / BUSY / DONE
package alu_seq_pkg;

  localparam int ALU_SEQ_WIDTH      = 32;
  localparam int ALU_SEQ_OPRN_WIDTH = 6;

  localparam logic [7:0] ALU_SEQ_OP_ADD = 8'h01;
  localparam logic [7:0] ALU_SEQ_OP_SUB = 8'h02;
  localparam logic [7:0] ALU_SEQ_OP_MUL = 8'h03;
  localparam logic [7:0] ALU_SEQ_OP_SHR = 8'h04;
  localparam logic [7:0] ALU_SEQ_OP_SHL = 8'h05;
  localparam logic [7:0] ALU_SEQ_OP_AND = 8'h06;
  localparam logic [7:0] ALU_SEQ_OP_OR  = 8'h07;
  localparam logic [7:0] ALU_SEQ_OP_NOR = 8'h08;
  localparam logic [7:0] ALU_SEQ_OP_SLT = 8'h09;

  typedef enum logic [1:0] {
    ALU_SEQ_IDLE = 2'd0,
    ALU_SEQ_BUSY = 2'd1,
    ALU_SEQ_DONE = 2'd2
  } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one multiplier bit per cycle
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and clear accumulator/counter
//   mcand, mplier   operands (sampled only when start is high)
//   done            high during the final iteration cycle
//   product         low WIDTH bits of the product, valid while done is high
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [WIDTH-1:0] acc_step;

  // The final partial sum is handed out combinationally so the top level can
  // register the product on the same edge that retires the last bit.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = active_q && (cnt_q == LAST);
  assign product  = acc_step;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = mcand;
      mplier_d = mplier;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with single-cycle ops and iterative multiply
// Optional feature macro: ALU_SEQ_OVF_EN (signed overflow flag for add/sub; OVF tied 0 otherwise)
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   IN_VALID / IN_READY    request handshake; OP1, OP2, OPRN captured on accept
//   OP1, OP2, OPRN         operands and opcode
//   OUT_VALID / OUT_READY  result handshake; OUT, ZERO, OVF held until accepted
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = ALU_SEQ_WIDTH,
  parameter int OPRN_WIDTH = ALU_SEQ_OPRN_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [WIDTH-1:0]      OP1,
  input  logic [WIDTH-1:0]      OP2,
  input  logic [OPRN_WIDTH-1:0] OPRN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [WIDTH-1:0]      OUT,
  output logic                  ZERO,
  output logic                  OVF
);

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  alu_seq_state_e   state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             in_ready;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             shamt_big;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (CLK),
    .rst     (RST),
    .start   (mul_start),
    .mcand   (OP1),
    .mplier  (OP2),
    .done    (mul_done),
    .product (mul_product)
  );

  assign sum       = OP1 + OP2;
  assign diff      = OP1 - OP2;
  assign shamt_big = (OP2 >= W_VAL);
  assign is_mul    = (OPRN == OPRN_WIDTH'(ALU_SEQ_OP_MUL));

  // Single-cycle datapath; evaluated on the live inputs and registered only
  // on accept, which is what captures the operands.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (OPRN)
      OPRN_WIDTH'(ALU_SEQ_OP_ADD): alu_res = sum;
      OPRN_WIDTH'(ALU_SEQ_OP_SUB): alu_res = diff;
      OPRN_WIDTH'(ALU_SEQ_OP_SHR): alu_res = shamt_big ? '0 : (OP1 >> OP2);
      OPRN_WIDTH'(ALU_SEQ_OP_SHL): alu_res = shamt_big ? '0 : (OP1 << OP2);
      OPRN_WIDTH'(ALU_SEQ_OP_AND): alu_res = OP1 & OP2;
      OPRN_WIDTH'(ALU_SEQ_OP_OR):  alu_res = OP1 | OP2;
      OPRN_WIDTH'(ALU_SEQ_OP_NOR): alu_res = ~(OP1 | OP2);
      OPRN_WIDTH'(ALU_SEQ_OP_SLT): alu_res = {{(WIDTH-1){1'b0}}, (OP1 < OP2)};
      default:                     alu_res = '0;
    endcase
`ifdef ALU_SEQ_OVF_EN
    // Overflow when the result sign departs from OP1 although the operand
    // signs make that impossible in infinite precision.
    if (OPRN == OPRN_WIDTH'(ALU_SEQ_OP_ADD)) begin
      alu_ovf = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum[WIDTH-1] != OP1[WIDTH-1]);
    end else if (OPRN == OPRN_WIDTH'(ALU_SEQ_OP_SUB)) begin
      alu_ovf = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (diff[WIDTH-1] != OP1[WIDTH-1]);
    end
`endif
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    zero_d    = zero_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_d     = ovf_q;
`endif
    mul_start = 1'b0;
    in_ready  = 1'b0;

    case (state_q)
      ALU_SEQ_IDLE: begin
        in_ready = 1'b1;
      end
      ALU_SEQ_BUSY: begin
        if (mul_done) begin
          out_d   = mul_product;
          zero_d  = (mul_product == '0);
`ifdef ALU_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = ALU_SEQ_DONE;
        end
      end
      ALU_SEQ_DONE: begin
        // Consumer draining the result frees the slot in the same cycle.
        in_ready = OUT_READY;
        if (OUT_READY) begin
          state_d = ALU_SEQ_IDLE;
        end
      end
      default: begin
        state_d = ALU_SEQ_IDLE;
      end
    endcase

    // A new accept from IDLE or DONE overrides the plain DONE->IDLE step,
    // giving back-to-back results with no bubble.
    accept = IN_VALID && in_ready;
    if (accept) begin
      if (is_mul) begin
        mul_start = 1'b1;
        state_d   = ALU_SEQ_BUSY;
      end else begin
        out_d     = alu_res;
        zero_d    = (alu_res == '0);
`ifdef ALU_SEQ_OVF_EN
        ovf_d     = alu_ovf;
`endif
        state_d   = ALU_SEQ_DONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ALU_SEQ_IDLE;
      out_q   <= '0;
      zero_q  <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = (state_q == ALU_SEQ_DONE);
  assign OUT       = out_q;
  assign ZERO      = zero_q;
`ifdef ALU_SEQ_OVF_EN
  assign OVF       = ovf_q;
`else
  assign OVF       = 1'b0;
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (build with or without ALU_SEQ_OVF_EN)
module tb_alu_seq;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] OP1 = '0;
  logic [W-1:0] OP2 = '0;
  logic [5:0]   OPRN = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b1;
  logic [W-1:0] OUT;
  logic         ZERO;
  logic         OVF;

  int checks = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;

  logic [W-1:0] ta [8];
  logic [W-1:0] tb [8];
  logic [5:0]   to [8];

  always #5 CLK = ~CLK;

  alu_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OP1       (OP1),
    .OP2       (OP2),
    .OPRN      (OPRN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT       (OUT),
    .ZERO      (ZERO),
    .OVF       (OVF)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ovf, zero, out}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [5:0] op);
    logic [W-1:0]   r;
    logic           v;
    longint         s;
    logic [2*W-1:0] p;
    r = '0;
    v = 1'b0;
    case (op)
      6'h01: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); v = (s > SMAX) || (s < SMIN); end
      6'h02: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); v = (s > SMAX) || (s < SMIN); end
      6'h03: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
      6'h04: r = (b >= W) ? '0 : (a >> b);
      6'h05: r = (b >= W) ? '0 : (a << b);
      6'h06: r = a & b;
      6'h07: r = a | b;
      6'h08: r = ~(a | b);
      6'h09: r = (a < b) ? 1 : 0;
      default: r = '0;
    endcase
`ifndef ALU_SEQ_OVF_EN
    v = 1'b0;
`endif
    return {v, (r == '0), r};
  endfunction

  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) begin
      check("result_pending", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out", OUT, mon_e[W-1:0]);
        check("zero", ZERO, mon_e[W]);
        check("ovf", OVF, mon_e[W+1]);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op,
                      output int stalls);
    OP1 = a;
    OP2 = b;
    OPRN = op;
    IN_VALID = 1'b1;
    stalls = 0;
    @(negedge CLK);
    while (!IN_READY && stalls < 100) begin
      @(negedge CLK);
      stalls++;
    end
    check("accept_ready", IN_READY, 1);
    exp_q.push_back(model(a, b, op));
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat, input bit busy_chk);
    int lat;
    lat = 1;
    while (!OUT_VALID && lat < 200) begin
      if (busy_chk) begin
        check("busy_in_ready", IN_READY, 0);
        if (lat == 5) OP1 = 32'h0000_1234;
      end
      @(posedge CLK);
      #1;
      lat++;
    end
    check(tag, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int st;
    ta = '{32'd1, 32'd31, 32'd1,  32'd9,  32'd11, 32'd11, 32'h7FFF_FFFF, 32'h8000_0000};
    tb = '{32'd5, 32'd2,  32'd40, 32'd3,  32'd15, 32'd11, 32'd1,         32'd1};
    to = '{6'h05, 6'h04,  6'h04,  6'h0F,  6'h09,  6'h09,  6'h01,         6'h02};

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_in_ready", IN_READY, 1);
    check("rst_out", OUT, 0);
    check("rst_zero", ZERO, 1);
    check("rst_ovf", OVF, 0);

    send(32'd15, 32'd3, 6'h01, st);
    wait_valid("lat_add", 1, 1'b0);
    @(posedge CLK); #1;
    send(32'd5, 32'd5, 6'h02, st);
    wait_valid("lat_sub", 1, 1'b0);
    @(posedge CLK); #1;

    send(32'hFFFF_FFF9, 32'hFFFF_FFFB, 6'h03, st);
    wait_valid("lat_mul", W + 1, 1'b1);
    @(posedge CLK); #1;

    // Back-pressure: result must hold, then drain concurrently with a new accept.
    OUT_READY = 1'b0;
    send(32'd11, 32'd2, 6'h06, st);
    wait_valid("lat_and", 1, 1'b0);
    repeat (10) begin
      @(negedge CLK);
      check("hold_out", OUT, 32'd2);
      check("hold_valid", OUT_VALID, 1);
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    send(32'd11, 32'd2, 6'h07, st);
    check("concurrent_stall", st, 0);
    wait_valid("lat_or", 1, 1'b0);
    @(posedge CLK); #1;

    // Back-to-back table with OUT_READY high: one accept per cycle.
    for (int i = 0; i < 8; i++) begin
      send(ta[i], tb[i], to[i], st);
      check("tput_stall", st, 0);
    end
    repeat (2) @(posedge CLK);
    #1;

    // Reset in the middle of a multiply discards it.
    send(32'd3, 32'd4, 6'h03, st);
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    check("mrst_out_valid", OUT_VALID, 0);
    check("mrst_in_ready", IN_READY, 1);
    check("mrst_out", OUT, 0);
    check("mrst_zero", ZERO, 1);
    repeat (40) begin
      @(posedge CLK);
      #1;
      check("mrst_no_result", OUT_VALID, 0);
    end
    send(32'd1, 32'd5, 6'h05, st);
    wait_valid("lat_shl_after_rst", 1, 1'b0);
    repeat (2) @(posedge CLK);
    #1;

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
